// File: rtl/cmd_scheduler_pkg.sv
// Shared command encodings, output FSM states and helpers for cmd_scheduler.
package tama_cmd_pkg;

  localparam logic [7:0] CMD_EAT   = 8'h65;
  localparam logic [7:0] CMD_PLAY  = 8'h70;
  localparam logic [7:0] CMD_BATH  = 8'h62;
  localparam logic [7:0] CMD_SLEEP = 8'h73;
  localparam logic [7:0] CMD_TALK  = 8'h74;
  localparam logic [7:0] CMD_WAKE  = 8'h77;
  localparam logic [7:0] CMD_IDLE  = 8'h00;

  localparam int NUM_BTN = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // True for the six bytes the stats block understands.
  function automatic logic is_legal_cmd(input logic [7:0] b);
    return (b == CMD_EAT)   || (b == CMD_PLAY) || (b == CMD_BATH) ||
           (b == CMD_SLEEP) || (b == CMD_TALK) || (b == CMD_WAKE);
  endfunction

  // Button index to command byte: e, p, b, s, t, w.
  function automatic logic [7:0] btn_to_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_EAT;
      3'd1:    return CMD_PLAY;
      3'd2:    return CMD_BATH;
      3'd3:    return CMD_SLEEP;
      3'd4:    return CMD_TALK;
      default: return CMD_WAKE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_scheduler_fifo.sv
// Small synchronous command queue; push and pop may coincide even when full.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // A pop frees the slot being written, so a full queue may still accept.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Merges UART and button commands into one queue and plays each out as a
// hold-then-release waveform on cmd_out.
module cmd_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        uart_data,
  input  logic                              uart_valid,
  input  logic [5:0]                        btn,
  output logic [7:0]                        cmd_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              drop
);

  import tama_cmd_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH+1);
  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAXC+1);

  logic [5:0]       sync1_reg, sync2_reg, prev_reg, pending_reg, pending_next;
  logic [5:0]       rise, clear;
  logic             uart_legal, can_push, push, pop, found;
  logic [2:0]       sel;
  logic [7:0]       push_data, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    count_next;
  sched_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       byte_reg, byte_next, cmd_reg, cmd_next;
  logic             busy_reg, busy_next, drop_reg, drop_next;

  // Per-button rising-edge detect and sticky pending flag; a fresh edge wins
  // over a clear landing on the same bit.
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      assign rise[gi]         = sync2_reg[gi] & ~prev_reg[gi];
      assign pending_next[gi] = (pending_reg[gi] & ~clear[gi]) | rise[gi];
    end
  endgenerate

  // Button synchronizer, edge history and pending flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      prev_reg    <= '0;
      pending_reg <= '0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      prev_reg    <= sync2_reg;
      pending_reg <= pending_next;
    end
  end

  // Enqueue arbiter: legal UART byte first, else lowest pending button.
  always_comb begin
    uart_legal = uart_valid && is_legal_cmd(uart_data);
    can_push   = !fifo_full || pop;
    push       = 1'b0;
    push_data  = CMD_IDLE;
    clear      = '0;
    drop_next  = 1'b0;
    found      = 1'b0;
    sel        = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!found && pending_reg[i]) begin
        found = 1'b1;
        sel   = i[2:0];
      end
    end
    if (uart_legal) begin
      if (can_push) begin
        push      = 1'b1;
        push_data = uart_data;
      end else begin
        drop_next = 1'b1;
      end
    end else if (found && can_push) begin
      push      = 1'b1;
      push_data = btn_to_cmd(sel);
      clear     = 6'b1 << sel;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output FSM next state, plus next values of the registered outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    byte_next  = byte_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          byte_next  = fifo_dout;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
    count_next = fifo_count + CW'(push) - CW'(pop);
    cmd_next   = (state_next == HOLD) ? byte_next : CMD_IDLE;
    busy_next  = (state_next != IDLE) || (count_next != '0);
  end

  // FSM state, hold/gap counter, latched byte and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      byte_reg  <= CMD_IDLE;
      cmd_reg   <= CMD_IDLE;
      busy_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      byte_reg  <= byte_next;
      cmd_reg   <= cmd_next;
      busy_reg  <= busy_next;
      drop_reg  <= drop_next;
    end
  end

  assign cmd_out = cmd_reg;
  assign busy    = busy_reg;
  assign drop    = drop_reg;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Randomized and directed bench for cmd_scheduler with a timeline-based model.
module tb_cmd_scheduler;

  localparam int H  = 4;
  localparam int G  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    uart_data = 8'h00;
  logic          uart_valid = 1'b0;
  logic [5:0]    btn = 6'h00;
  logic [7:0]    cmd_out;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          drop;

  int vectors = 0;
  int miscompares = 0;

  cmd_scheduler #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .btn        (btn),
    .cmd_out    (cmd_out),
    .busy       (busy),
    .fifo_count (fifo_count),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Commands are modelled as a queue plus a timeline: a pop at edge p drives
  // the byte after edges p..p+H-1, zero afterwards, and the sequencer can pop
  // again at the first edge after p+H+G.
  logic [7:0] m_q[$];
  logic [7:0] btn_bytes [6] = '{8'h65, 8'h70, 8'h62, 8'h73, 8'h74, 8'h77};
  logic [5:0] m_pend, h0, h1, h2, m_rise, m_clr;
  bit         m_active, m_pop, m_legal, m_can, m_push, model_ok;
  logic [7:0] m_cur, m_pbyte;
  int         e_cnt = 0;
  int         m_pop_edge;
  logic [7:0] exp_cmd;
  bit         exp_busy, exp_drop;
  int         exp_cnt;

  always @(posedge clk) begin
    e_cnt++;
    if (!rst_n) begin
      m_q.delete();
      m_pend = 0; h0 = 0; h1 = 0; h2 = 0;
      m_active = 0; m_cur = 0; m_pop_edge = 0;
      exp_drop = 0;
    end else begin
      m_pop   = (!m_active || e_cnt > m_pop_edge + H + G) && (m_q.size() > 0);
      m_legal = uart_valid && (uart_data inside {8'h65, 8'h70, 8'h62, 8'h73, 8'h74, 8'h77});
      m_can   = (m_q.size() < D) || m_pop;
      m_rise  = h1 & ~h2;
      m_push  = 0; m_pbyte = 0; m_clr = 0;
      if (m_legal) begin
        if (m_can) begin m_push = 1; m_pbyte = uart_data; end
      end else if (m_can) begin
        for (int i = 5; i >= 0; i--)
          if (m_pend[i]) begin m_push = 1; m_pbyte = btn_bytes[i]; m_clr = 6'(1) << i; end
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_active = 1;
        m_pop_edge = e_cnt;
      end
      if (m_push) m_q.push_back(m_pbyte);
      h2 = h1; h1 = h0; h0 = btn;
      exp_drop = m_legal && !m_can;
    end
    exp_cmd  = (m_active && e_cnt < m_pop_edge + H) ? m_cur : 8'h00;
    exp_busy = (m_active && e_cnt < m_pop_edge + H + G) || (m_q.size() > 0);
    exp_cnt  = m_q.size();
    model_ok = 1;
  end

  // ---------------- compare + emission monitor ----------------
  logic [7:0] dut_log[$];
  int         dut_log_t[$];
  int         dut_drops = 0;
  logic [7:0] last_cmd = 8'h00;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmd_out", 32'(cmd_out), 32'(exp_cmd));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("fifo_count", 32'(fifo_count), 32'(exp_cnt));
      if (cmd_out != 8'h00 && last_cmd == 8'h00) begin
        dut_log.push_back(cmd_out);
        dut_log_t.push_back(e_cnt);
      end
      if (drop) dut_drops++;
      last_cmd = cmd_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    dut_log.delete();
    dut_log_t.delete();
    dut_drops = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  logic [7:0] seq6 [6] = '{8'h65, 8'h70, 8'h62, 8'h74, 8'h73, 8'h77};

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_cmd", 32'(cmd_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_cnt", 32'(fifo_count), 32'h0);
    rst_n = 1'b1;
    repeat (6) step();

    // Single UART command timeline
    uart_valid = 1'b1; uart_data = 8'h65;
    step();
    uart_valid = 1'b0;
    chk("t1_cnt_k", 32'(fifo_count), 32'd1);
    chk("t1_busy_k", 32'(busy), 32'd1);
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 1) begin chk("t1_cmd_k1", 32'(cmd_out), 32'h65); chk("t1_cnt_k1", 32'(fifo_count), 32'd0); end
      if (j == 4) chk("t1_cmd_k4", 32'(cmd_out), 32'h65);
      if (j == 5) chk("t1_cmd_k5", 32'(cmd_out), 32'h00);
      if (j == 8) begin chk("t1_cmd_k8", 32'(cmd_out), 32'h00); chk("t1_busy_k8", 32'(busy), 32'd1); end
      if (j == 9) chk("t1_busy_k9", 32'(busy), 32'd0);
    end
    $display("test single_uart done");

    // Illegal byte ignored
    uart_valid = 1'b1; uart_data = 8'h41;
    step();
    uart_valid = 1'b0;
    chk("t2_cnt", 32'(fifo_count), 32'd0);
    chk("t2_drop", 32'(drop), 32'd0);
    repeat (3) step();
    chk("t2_cmd", 32'(cmd_out), 32'h00);
    chk("t2_busy", 32'(busy), 32'd0);
    $display("test illegal_byte done");

    // Burst of five and of six legal bytes
    for (int n = 5; n <= 6; n++) begin
      clear_log();
      for (int i = 0; i < n; i++) begin
        uart_valid = 1'b1; uart_data = seq6[i];
        step();
      end
      uart_valid = 1'b0;
      wait_idle();
      step();
      chk("burst_emitted", 32'(dut_log.size()), 32'd5);
      chk("burst_drops", 32'(dut_drops), (n == 5) ? 32'd0 : 32'd1);
      if (dut_log.size() == 5) begin
        for (int i = 0; i < 5; i++) chk("burst_order", 32'(dut_log[i]), 32'(seq6[i]));
        chk("burst_spacing", 32'(dut_log_t[1] - dut_log_t[0]), 32'd9);
      end
      $display("test burst_%0d done", n);
    end

    // Held button gives one command
    clear_log();
    btn = 6'b000001;
    repeat (100) step();
    btn = 6'b000000;
    repeat (5) step();
    wait_idle();
    chk("held_count", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) chk("held_byte", 32'(dut_log[0]), 32'h65);
    $display("test held_button done");

    // UART vs button in the same enqueue cycle
    repeat (5) step();
    clear_log();
    btn = 6'b001000;
    repeat (3) step();
    uart_valid = 1'b1; uart_data = 8'h70;
    step();
    uart_valid = 1'b0;
    repeat (5) step();
    btn = 6'b000000;
    wait_idle();
    repeat (4) step();
    chk("contend_count", 32'(dut_log.size()), 32'd2);
    if (dut_log.size() == 2) begin
      chk("contend_first", 32'(dut_log[0]), 32'h70);
      chk("contend_second", 32'(dut_log[1]), 32'h73);
    end
    $display("test uart_button_contention done");

    // Reset mid-HOLD with two queued
    for (int i = 0; i < 3; i++) begin
      uart_valid = 1'b1; uart_data = seq6[i];
      step();
    end
    uart_valid = 1'b0;
    step();
    chk("rst_pre_cnt", 32'(fifo_count), 32'd2);
    chk("rst_pre_cmd", 32'(cmd_out), 32'h65);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_cmd", 32'(cmd_out), 32'h00);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clear_log();
    repeat (40) step();
    chk("rst_no_emit", 32'(dut_log.size()), 32'd0);
    $display("test reset_mid_hold done");

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        uart_valid = 1'b1;
        uart_data  = ($urandom_range(0, 9) < 7) ? seq6[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      end else begin
        uart_valid = 1'b0;
        uart_data  = 8'($urandom_range(0, 255));
      end
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 39) == 0) btn[b] = ~btn[b];
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst_n = 1'b1; uart_valid = 1'b0; btn = 6'h00;
    repeat (8) step();
    wait_idle();
    repeat (20) step();
    wait_idle();
    $display("test random done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
